matrix_wb_sequencer: RTL and testbench
======================================

Name: matrix_wb_sequencer

Overview:
Write-back sequencer that drives the write side of the scalar/matrix register file: w_select, w_regs_addr, w_regs_data and w_matrix_data.
- Accepts write-back requests from the MEM/WB stage over a valid/ready handshake.
- Each request is a scalar register write, one matrix slice write, or a masked whole-matrix write.
- Masked whole-matrix writes are either issued as a single whole-matrix beat or broken into per-slice beats over several cycles.
- All outputs are registered, so the register file sees a clean one-write-per-cycle stream.

Parameters:
WHOLE_WRITE_EN, 1, when 1 a kind-11 request with mask 4'hF issues one w_select=11 beat; when 0 every kind-11 request is split into slice beats
NSLICE, 4, number of 32-bit matrix slices (fixed at 4; the matrix is 128 bits)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (combinational: high only in IDLE)
req_kind  in  2  00 no-op, 01 scalar reg, 10 one slice, 11 masked matrix
req_addr  in  5  scalar rd (kind 01) or slice index in [1:0] (kind 10)
req_data  in  32  scalar or slice data
req_matrix  in  128  matrix data, slice i = bits [32i+31:32i]
req_mask  in  4  slice enable mask for kind 11
flush  in  1  synchronous abort of any sequence
busy  out  1  state != IDLE
w_select  out  2  00 none, 01 reg, 10 slice, 11 whole
w_regs_addr  out  5  destination register or slice index
w_regs_data  out  32  write data
w_matrix_data  out  128  whole-matrix data

Behaviour:
- Reset (async, rst=1): state IDLE, rem_mask=0, w_select=00, w_regs_addr=0, w_regs_data=0, w_matrix_data=0, busy=0.
- Accept = req_valid & req_ready & !flush. If no accept and state IDLE, w_select<=00 at the next edge.
- Latency: a request accepted in cycle N appears on the outputs in cycle N+1.
- Kind 00: consumed, no write (w_select=00).
- Kind 01:
  - addr != 0: w_select=01, addr and data passed through.
  - addr == 0: dropped, w_select=00.
- Kind 10: w_select=10, w_regs_addr = {3'b0, req_addr[1:0]}, w_regs_data = req_data.
- Kind 11:
  - req_matrix is latched into w_matrix_data on accept (w_matrix_data is otherwise held).
  - mask == 0: no write.
  - mask == F and WHOLE_WRITE_EN=1: one beat, w_select=11, stay IDLE.
  - Otherwise slice beats are issued in ascending index order, lowest set bit first, one per cycle:
    - w_select=10, w_regs_addr = index, w_regs_data = that slice.
    - The first beat is issued at edge N; rem_mask = mask minus that bit.
    - Go to SEQ if rem_mask != 0, otherwise stay IDLE.
- SEQ:
  - req_ready=0.
  - Each edge issues the next set bit of rem_mask and clears it.
  - The edge that clears the last bit returns to IDLE, so ready is high in the same cycle the final beat is visible.
  - Back-to-back requests produce no bubble.
  - Full mask with WHOLE_WRITE_EN=0: beats in N+1..N+4; next accept possible in N+4.
- flush:
  - Priority over everything except reset.
  - Next edge: state IDLE, rem_mask=0, w_select=00.
  - A request presented in the same cycle is not accepted (req_ready is still high, but accept is gated by flush).
- Reset mid-sequence: the remaining beats are discarded.
- Only one w_select value is driven per cycle; scalar and matrix writes never coincide.

Decomposition:
- Shared package (mwb_pkg):
  - WSEL_NONE/WSEL_REG/WSEL_SLICE/WSEL_WHOLE (2'b00..2'b11).
  - KIND_NOP/KIND_REG/KIND_SLICE/KIND_MAT.
  - State encodings ST_IDLE/ST_SEQ.
  - SLICE_W=32, MAT_W=128.
- Sub-module mwb_slice_pick: combinational lowest-set-bit priority encoder.
  - Input: 4-bit mask.
  - Outputs: 2-bit index, valid, and the mask with that bit cleared.
  - Used both on accept and in SEQ.

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle -> all outputs 0 immediately, busy=0, req_ready=1.
- Kind 01, addr=5, data=32'hDEADBEEF at cycle N -> cycle N+1: w_select=01, addr=5, data=DEADBEEF. Same request with addr=0 -> w_select=00.
- Kind 11, mask=F, matrix=128'h44444444_33333333_22222222_11111111:
  - WHOLE_WRITE_EN=1 -> single beat, w_select=11, w_matrix_data=that matrix.
  - WHOLE_WRITE_EN=0 -> four beats: (10,0,11111111), (10,1,22222222), (10,2,33333333), (10,3,44444444). req_ready low for 3 cycles.
- Kind 11, mask=4'b1010 -> beats slice1 then slice3. Then a kind-01 request held valid is accepted in the cycle of the slice3 beat and appears on the next cycle with no gap.
- flush asserted during the second beat of a mask-F split -> next cycle w_select=00, busy=0, no further slice beats.
- Kind 11 with mask=0, followed by kind 00 -> w_select stays 00, w_matrix_data updates to the latched matrix, req_ready stays 1.

Source files
------------

// File: rtl/mwb_pkg.sv
// Shared encodings and helpers for the matrix write-back sequencer.
package mwb_pkg;

  localparam int SLICE_W = 32;
  localparam int MAT_W   = 128;

  localparam logic [1:0] WSEL_NONE  = 2'b00;
  localparam logic [1:0] WSEL_REG   = 2'b01;
  localparam logic [1:0] WSEL_SLICE = 2'b10;
  localparam logic [1:0] WSEL_WHOLE = 2'b11;

  localparam logic [1:0] KIND_NOP   = 2'b00;
  localparam logic [1:0] KIND_REG   = 2'b01;
  localparam logic [1:0] KIND_SLICE = 2'b10;
  localparam logic [1:0] KIND_MAT   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  // Extract 32-bit slice idx from a 128-bit matrix word.
  function automatic logic [SLICE_W-1:0] slice_of(input logic [MAT_W-1:0] mat,
                                                  input logic [1:0] idx);
    logic [SLICE_W-1:0] s;
    case (idx)
      2'd0:    s = mat[31:0];
      2'd1:    s = mat[63:32];
      2'd2:    s = mat[95:64];
      default: s = mat[127:96];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mwb_slice_pick.sv
// Lowest-set-bit priority encoder over the 4-slice write mask.
module mwb_slice_pick (
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       valid,
  output logic [3:0] rest
);

  // Pick the lowest enabled slice and report the mask with it removed.
  always_comb begin
    valid = |mask;
    idx   = 2'd0;
    if (mask[0])      idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else if (mask[3]) idx = 2'd3;
    rest  = mask & (mask - 4'd1);
  end

endmodule

// File: rtl/matrix_wb_sequencer.sv
// Write-back sequencer feeding the scalar/matrix register file write port.
// State table:
//   ST_IDLE | ready for a request; at most one write beat issued per accept
//   ST_SEQ  | draining remaining slice beats of a split matrix write
module matrix_wb_sequencer
  import mwb_pkg::*;
#(
  parameter bit WHOLE_WRITE_EN = 1'b1,
  parameter int NSLICE         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_kind,
  input  logic [4:0]          req_addr,
  input  logic [31:0]         req_data,
  input  logic [127:0]        req_matrix,
  input  logic [NSLICE-1:0]   req_mask,
  input  logic                flush,
  output logic                busy,
  output logic [1:0]          w_select,
  output logic [4:0]          w_regs_addr,
  output logic [31:0]         w_regs_data,
  output logic [127:0]        w_matrix_data
);

  state_t              state;
  logic [NSLICE-1:0]   rem_mask;
  logic [NSLICE-1:0]   pick_in;
  logic [1:0]          pick_idx;
  logic                pick_valid;
  logic [NSLICE-1:0]   pick_rest;
  logic                accept;

  // One encoder serves both the incoming mask and the remaining mask in SEQ.
  always_comb begin
    pick_in   = (state == ST_SEQ) ? rem_mask : req_mask;
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    accept    = req_valid & req_ready & ~flush;
  end

  mwb_slice_pick u_pick (
    .mask  (pick_in),
    .idx   (pick_idx),
    .valid (pick_valid),
    .rest  (pick_rest)
  );

  // Sequencer FSM with registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rem_mask      <= '0;
      w_select      <= WSEL_NONE;
      w_regs_addr   <= '0;
      w_regs_data   <= '0;
      w_matrix_data <= '0;
    end else if (flush) begin
      state    <= ST_IDLE;
      rem_mask <= '0;
      w_select <= WSEL_NONE;
    end else if (state == ST_SEQ) begin
      // Slices come from the matrix latched at accept time.
      w_select    <= WSEL_SLICE;
      w_regs_addr <= {3'b000, pick_idx};
      w_regs_data <= slice_of(w_matrix_data, pick_idx);
      rem_mask    <= pick_rest;
      if (pick_rest == '0) state <= ST_IDLE;
    end else if (accept) begin
      case (req_kind)
        KIND_REG: begin
          if (req_addr != 5'd0) begin
            w_select    <= WSEL_REG;
            w_regs_addr <= req_addr;
            w_regs_data <= req_data;
          end else begin
            w_select <= WSEL_NONE;
          end
        end
        KIND_SLICE: begin
          w_select    <= WSEL_SLICE;
          w_regs_addr <= {3'b000, req_addr[1:0]};
          w_regs_data <= req_data;
        end
        KIND_MAT: begin
          w_matrix_data <= req_matrix;
          if (!pick_valid) begin
            w_select <= WSEL_NONE;
          end else if (WHOLE_WRITE_EN && (req_mask == '1)) begin
            w_select <= WSEL_WHOLE;
          end else begin
            // First slice beat goes out with the accept; the rest follow in SEQ.
            w_select    <= WSEL_SLICE;
            w_regs_addr <= {3'b000, pick_idx};
            w_regs_data <= slice_of(req_matrix, pick_idx);
            rem_mask    <= pick_rest;
            if (pick_rest != '0) state <= ST_SEQ;
          end
        end
        default: w_select <= WSEL_NONE;
      endcase
    end else begin
      w_select <= WSEL_NONE;
    end
  end

endmodule

// File: tb/tb_matrix_wb_sequencer.sv
// Bench for matrix_wb_sequencer: both WHOLE_WRITE_EN settings side by side,
// checked against a beat-list reference model.
module tb_matrix_wb_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic [1:0]   req_kind = 2'b00;
  logic [4:0]   req_addr = 5'd0;
  logic [31:0]  req_data = 32'd0;
  logic [127:0] req_matrix = 128'd0;
  logic [3:0]   req_mask = 4'd0;
  logic         flush = 1'b0;

  logic         rdy   [2];
  logic         bsy   [2];
  logic [1:0]   wsel  [2];
  logic [4:0]   waddr [2];
  logic [31:0]  wdata [2];
  logic [127:0] wmat  [2];

  always #5 clk = ~clk;

  // Index 0: split every matrix write; index 1: whole-matrix beat allowed.
  matrix_wb_sequencer #(.WHOLE_WRITE_EN(1'b0), .NSLICE(4)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_kind(req_kind), .req_addr(req_addr), .req_data(req_data),
    .req_matrix(req_matrix), .req_mask(req_mask), .flush(flush), .busy(bsy[0]),
    .w_select(wsel[0]), .w_regs_addr(waddr[0]), .w_regs_data(wdata[0]),
    .w_matrix_data(wmat[0]));

  matrix_wb_sequencer #(.WHOLE_WRITE_EN(1'b1), .NSLICE(4)) dut_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_kind(req_kind), .req_addr(req_addr), .req_data(req_data),
    .req_matrix(req_matrix), .req_mask(req_mask), .flush(flush), .busy(bsy[1]),
    .w_select(wsel[1]), .w_regs_addr(waddr[1]), .w_regs_data(wdata[1]),
    .w_matrix_data(wmat[1]));

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: each accepted request expands into a list of write beats;
  // the first appears after the accept edge, the rest one per edge after that.
  typedef struct packed {
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t        pend   [2][4];
  int           pend_n [2];
  logic [1:0]   e_sel  [2];
  logic [4:0]   e_addr [2];
  logic [31:0]  e_data [2];
  logic [127:0] e_mat  [2];

  localparam logic [127:0] MAT_A = 128'h44444444_33333333_22222222_11111111;
  logic [31:0] sl [4];

  typedef struct {
    logic [1:0]   kind;
    logic [4:0]   addr;
    logic [31:0]  data;
    logic [3:0]   mask;
    logic [127:0] mat;
    logic [1:0]   e_sel;
    logic [4:0]   e_addr;
    logic [31:0]  e_data;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pend_n[m] = 0;
      e_sel[m]  = 2'b00;
      e_addr[m] = 5'd0;
      e_data[m] = 32'd0;
      e_mat[m]  = 128'd0;
    end
  endtask

  task automatic apply_beat(input int m, input beat_t b);
    e_sel[m]  = b.sel;
    e_addr[m] = b.addr;
    e_data[m] = b.data;
  endtask

  task automatic model_edge(input int m);
    beat_t nb[$];
    beat_t b;
    if (flush) begin
      pend_n[m] = 0;
      e_sel[m]  = 2'b00;
    end else if (pend_n[m] > 0) begin
      b = pend[m][0];
      for (int j = 0; j < 3; j++) pend[m][j] = pend[m][j+1];
      pend_n[m]--;
      apply_beat(m, b);
    end else if (req_valid) begin
      case (req_kind)
        2'b01: if (req_addr != 5'd0) nb.push_back('{2'b01, req_addr, req_data});
        2'b10: nb.push_back('{2'b10, {3'b000, req_addr[1:0]}, req_data});
        2'b11: begin
          e_mat[m] = req_matrix;
          if (m == 1 && req_mask == 4'hF)
            nb.push_back('{2'b11, e_addr[m], e_data[m]});
          else
            for (int i = 0; i < 4; i++)
              if (req_mask[i]) nb.push_back('{2'b10, 5'(i), req_matrix[32*i +: 32]});
        end
        default: ;
      endcase
      if (nb.size() == 0) begin
        e_sel[m] = 2'b00;
      end else begin
        apply_beat(m, nb[0]);
        for (int j = 1; j < nb.size(); j++) pend[m][j-1] = nb[j];
        pend_n[m] = nb.size() - 1;
      end
    end else begin
      e_sel[m] = 2'b00;
    end
  endtask

  task automatic check_out(input int m, input string tag);
    chk($sformatf("%s_sel_m%0d", tag, m), wsel[m], e_sel[m]);
    if (e_sel[m] == 2'b01 || e_sel[m] == 2'b10) begin
      chk($sformatf("%s_addr_m%0d", tag, m), waddr[m], e_addr[m]);
      chk($sformatf("%s_data_m%0d", tag, m), wdata[m], e_data[m]);
    end
    chk($sformatf("%s_mat_m%0d", tag, m), wmat[m], e_mat[m]);
    chk($sformatf("%s_ready_m%0d", tag, m), rdy[m], pend_n[m] == 0);
    chk($sformatf("%s_busy_m%0d", tag, m), bsy[m], pend_n[m] != 0);
  endtask

  task automatic step(input string tag);
    #1;
    for (int m = 0; m < 2; m++)
      chk($sformatf("%s_preready_m%0d", tag, m), rdy[m], pend_n[m] == 0);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_out(0, tag);
    check_out(1, tag);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      check_out(m, "reset");
      chk($sformatf("reset_addr_m%0d", m), waddr[m], 5'd0);
      chk($sformatf("reset_data_m%0d", m), wdata[m], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    flush     = 1'b0;
    req_kind  = 2'b00;
  endtask

  task automatic drive(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] mk, input logic [127:0] mt);
    req_valid  = 1'b1;
    req_kind   = k;
    req_addr   = a;
    req_data   = d;
    req_mask   = mk;
    req_matrix = mt;
  endtask

  initial begin
    int lowcnt;
    sl[0] = 32'h11111111; sl[1] = 32'h22222222;
    sl[2] = 32'h33333333; sl[3] = 32'h44444444;

    vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 4'h0, 128'd0, 2'b01, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{2'b01, 5'd0,  32'hDEADBEEF, 4'h0, 128'd0, 2'b00, 5'd0,  32'd0};
    vecs[2] = '{2'b10, 5'h16, 32'hCAFEF00D, 4'h0, 128'd0, 2'b10, 5'd2,  32'hCAFEF00D};
    vecs[3] = '{2'b00, 5'd9,  32'h0BADF00D, 4'hF, 128'd0, 2'b00, 5'd0,  32'd0};
    vecs[4] = '{2'b11, 5'd0,  32'd0,        4'h4, MAT_A,  2'b10, 5'd2,  32'h33333333};
    vecs[5] = '{2'b11, 5'd0,  32'd0,        4'h0, MAT_A,  2'b00, 5'd0,  32'd0};
    vecs[6] = '{2'b01, 5'd31, 32'h00000001, 4'h0, 128'd0, 2'b01, 5'd31, 32'h00000001};

    model_reset();
    #1;
    do_reset();

    // Single-beat requests, identical in both modes.
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].kind, vecs[v].addr, vecs[v].data, vecs[v].mask, vecs[v].mat);
      step($sformatf("vec%0d", v));
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vec%0d_tsel_m%0d", v, m), wsel[m], vecs[v].e_sel);
        if (vecs[v].e_sel != 2'b00) begin
          chk($sformatf("vec%0d_taddr_m%0d", v, m), waddr[m], vecs[v].e_addr);
          chk($sformatf("vec%0d_tdata_m%0d", v, m), wdata[m], vecs[v].e_data);
        end
      end
      idle_inputs();
      step($sformatf("vec%0d_idle", v));
    end

    // Full mask: whole beat vs four slice beats with ready low for three cycles.
    drive(2'b11, 5'd0, 32'd0, 4'hF, MAT_A);
    step("full");
    idle_inputs();
    chk("full_whole_sel", wsel[1], 2'b11);
    chk("full_whole_mat", wmat[1], MAT_A);
    chk("full_split_sel0", wsel[0], 2'b10);
    chk("full_split_addr0", waddr[0], 5'd0);
    chk("full_split_data0", wdata[0], sl[0]);
    lowcnt = (rdy[0] == 1'b0) ? 1 : 0;
    for (int i = 1; i < 4; i++) begin
      step($sformatf("full_b%0d", i));
      chk($sformatf("full_split_sel%0d", i), wsel[0], 2'b10);
      chk($sformatf("full_split_addr%0d", i), waddr[0], 5'(i));
      chk($sformatf("full_split_data%0d", i), wdata[0], sl[i]);
      if (rdy[0] == 1'b0) lowcnt++;
    end
    chk("full_ready_low_cycles", lowcnt, 3);
    step("full_after");

    // Sparse mask followed by a held scalar request: no bubble.
    drive(2'b11, 5'd0, 32'd0, 4'b1010, MAT_A);
    step("sparse1");
    chk("sparse_b1_addr", waddr[0], 5'd1);
    chk("sparse_b1_data", wdata[0], sl[1]);
    drive(2'b01, 5'd7, 32'h12345678, 4'h0, 128'd0);
    step("sparse3");
    chk("sparse_b3_addr", waddr[0], 5'd3);
    chk("sparse_b3_data", wdata[0], sl[3]);
    chk("sparse_b3_ready", rdy[0], 1'b1);
    step("sparse_next");
    chk("sparse_next_sel", wsel[0], 2'b01);
    chk("sparse_next_addr", waddr[0], 5'd7);
    idle_inputs();
    step("sparse_idle");

    // Flush during the second beat of a split.
    drive(2'b11, 5'd0, 32'd0, 4'hF, MAT_A);
    step("flush_b0");
    idle_inputs();
    step("flush_b1");
    flush = 1'b1;
    step("flush_hit");
    chk("flush_sel", wsel[0], 2'b00);
    chk("flush_busy", bsy[0], 1'b0);
    flush = 1'b0;
    step("flush_after");
    chk("flush_after_sel", wsel[0], 2'b00);
    // Flush beside a valid request in IDLE blocks the accept.
    drive(2'b01, 5'd3, 32'hA5A5A5A5, 4'h0, 128'd0);
    flush = 1'b1;
    step("flush_idle");
    chk("flush_idle_sel", wsel[1], 2'b00);
    idle_inputs();
    step("flush_idle_after");

    // Empty mask still latches the matrix; then a no-op.
    drive(2'b11, 5'd0, 32'd0, 4'h0, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978);
    step("mask0");
    chk("mask0_sel", wsel[0], 2'b00);
    chk("mask0_mat", wmat[0], 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978);
    drive(2'b00, 5'd0, 32'd0, 4'h0, 128'd0);
    step("nop");
    chk("nop_mat", wmat[1], 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978);
    chk("nop_ready", rdy[1], 1'b1);
    idle_inputs();

    // Reset mid-sequence drops the remaining beats.
    drive(2'b11, 5'd0, 32'd0, 4'hF, MAT_A);
    step("rstseq_b0");
    idle_inputs();
    step("rstseq_b1");
    do_reset();
    step("rstseq_after");
    chk("rstseq_sel", wsel[0], 2'b00);

    // Randomized traffic against the model.
    for (int it = 0; it < 500; it++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_kind   = 2'($urandom);
      req_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      req_data   = $urandom;
      req_matrix = {$urandom, $urandom, $urandom, $urandom};
      req_mask   = 4'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      step("rand");
      if ($urandom_range(0, 99) == 0) begin
        idle_inputs();
        do_reset();
      end
    end
    idle_inputs();
    step("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
